// File: rtl/msj_encoder_feedback.sv
// rtl/msj_encoder_feedback.sv - quadrature decoder, velocity window and controller update strobe
// for one MSJ joint.
module msj_encoder_feedback #(
  parameter int UPDATE_PERIOD = 50000,
  parameter int FILTER_CYCLES = 3,
  parameter int ERR_WIDTH     = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 enable,
  input  logic                 invert,
  input  logic                 zero_position,
  output logic signed [31:0]   position,
  output logic signed [31:0]   velocity,
  output logic                 update_controller,
  output logic [ERR_WIDTH-1:0] error_count
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int PW = $clog2(UPDATE_PERIOD);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES);
  localparam logic [PW-1:0] P_LAST = PW'(UPDATE_PERIOD - 1);

  logic               a_s1, a_s2, b_s1, b_s2;
  logic [1:0]         syn, cand, acc, last_state, delta;
  logic [FW-1:0]      stable_cnt, stable_next;
  logic               acc_pulse, primed, illegal;
  logic [PW-1:0]      period_cnt;
  logic signed [31:0] snapshot, raw_step, step, pos_next;

  // Gray state to ring index so a forward step is always +1 modulo 4.
  function automatic logic [1:0] gray_idx(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  always_comb begin
    syn         = {a_s2, b_s2};
    stable_next = (syn == cand) ? stable_cnt + 1'b1 : FW'(1);
    delta       = gray_idx(acc) - gray_idx(last_state);
    raw_step    = 32'sd0;
    illegal     = 1'b0;
    if (acc_pulse && primed) begin
      case (delta)
        2'd1:    raw_step = 32'sd1;
        2'd3:    raw_step = -32'sd1;
        2'd2:    illegal  = 1'b1;
        default: raw_step = 32'sd0;
      endcase
    end
    step     = invert ? -raw_step : raw_step;
    pos_next = position + step;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_s1              <= 1'b0;
      a_s2              <= 1'b0;
      b_s1              <= 1'b0;
      b_s2              <= 1'b0;
      cand              <= 2'b00;
      acc               <= 2'b00;
      last_state        <= 2'b00;
      stable_cnt        <= '0;
      acc_pulse         <= 1'b0;
      primed            <= 1'b0;
      error_count       <= '0;
      position          <= 32'sd0;
      velocity          <= 32'sd0;
      snapshot          <= 32'sd0;
      period_cnt        <= '0;
      update_controller <= 1'b0;
    end else begin
      a_s1 <= enc_a;
      a_s2 <= a_s1;
      b_s1 <= enc_b;
      b_s2 <= b_s1;
      cand <= syn;

      // Accept a new state only after it has held unchanged for FILTER_CYCLES samples.
      acc_pulse <= 1'b0;
      if (syn == acc) begin
        stable_cnt <= '0;
      end else if (stable_next == F_LAST) begin
        acc        <= syn;
        stable_cnt <= '0;
        acc_pulse  <= 1'b1;
      end else begin
        stable_cnt <= stable_next;
      end

      if (acc_pulse) begin
        last_state <= acc;
        primed     <= 1'b1;
      end

      if (illegal && !(&error_count))
        error_count <= error_count + 1'b1;

      position <= zero_position ? 32'sd0 : pos_next;

      if (!enable) begin
        period_cnt        <= '0;
        update_controller <= 1'b0;
        velocity          <= 32'sd0;
        snapshot          <= zero_position ? 32'sd0 : pos_next;
      end else if (period_cnt == P_LAST) begin
        period_cnt        <= '0;
        update_controller <= 1'b1;
        velocity          <= zero_position ? 32'sd0 : pos_next - snapshot;
        snapshot          <= zero_position ? 32'sd0 : pos_next;
      end else begin
        period_cnt        <= period_cnt + 1'b1;
        update_controller <= 1'b0;
        velocity          <= zero_position ? 32'sd0 : velocity;
        snapshot          <= zero_position ? 32'sd0 : snapshot;
      end
    end
  end
endmodule

// File: tb/tb_msj_encoder_feedback.sv
// tb/tb_msj_encoder_feedback.sv - self-checking bench for msj_encoder_feedback.
module tb_msj_encoder_feedback;
  localparam int P  = 1000;
  localparam int F  = 3;
  localparam int EW = 16;

  logic                clock = 1'b0;
  logic                reset_n, enc_a, enc_b, enable, invert, zero_position;
  logic signed [31:0]  position, velocity;
  logic                update_controller;
  logic [EW-1:0]       error_count;

  int                  checks = 0;
  int                  errors = 0;
  int                  cyc = 0;
  int                  strobe_total = 0;
  int                  idx = 1;
  logic signed [31:0]  mpos = 32'sd0;
  logic signed [31:0]  exp_q[$];

  typedef struct {
    int                 n;
    logic               inv;
    logic signed [31:0] exp;
  } vec_t;
  vec_t tbl[3];

  msj_encoder_feedback #(
    .UPDATE_PERIOD(P),
    .FILTER_CYCLES(F),
    .ERR_WIDTH(EW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .enable(enable),
    .invert(invert),
    .zero_position(zero_position),
    .position(position),
    .velocity(velocity),
    .update_controller(update_controller),
    .error_count(error_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (update_controller) strobe_total <= strobe_total + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] gray(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic steps(input int n);
    int cnt;
    int dir;
    cnt = (n < 0) ? -n : n;
    dir = (n < 0) ? 3 : 1;
    for (int k = 0; k < cnt; k++) begin
      @(negedge clock);
      idx = (idx + dir) % 4;
      {enc_a, enc_b} = gray(idx);
      mpos = mpos + (((n < 0) ^ invert) ? -32'sd1 : 32'sd1);
      repeat (20) @(posedge clock);
    end
  endtask

  task automatic wait_strobe(output int at_cyc);
    bit seen;
    seen   = 1'b0;
    at_cyc = 0;
    for (int k = 0; k < 2 * P + 10 && !seen; k++) begin
      @(negedge clock);
      if (update_controller) begin
        seen   = 1'b1;
        at_cyc = cyc;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout: got none expected strobe within %0d clocks", 2 * P + 10);
    end
  endtask

  initial begin
    int t0, t1, t2, lat, s0, s1, n;
    bit found;

    tbl[0] = '{39, 1'b0, 32'sd40};
    tbl[1] = '{40, 1'b1, 32'sd0};
    tbl[2] = '{17, 1'b0, 32'sd17};

    reset_n = 1'b0; enable = 1'b0; invert = 1'b0; zero_position = 1'b0;
    {enc_a, enc_b} = gray(idx);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_position", position, 32'd0);
    check("rst_velocity", velocity, 32'd0);
    check("rst_update", 32'(update_controller), 32'd0);
    check("rst_errors", 32'(error_count), 32'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    check("prime_no_count", position, 32'd0);
    enable = 1'b1;

    @(negedge clock);
    idx = (idx + 1) % 4;
    {enc_a, enc_b} = gray(idx);
    mpos = 32'sd1;
    lat = 0; found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clock);
      #1;
      lat++;
      if (position == 32'sd1) found = 1'b1;
    end
    check("latency", lat, 32'd6);
    repeat (20) @(posedge clock);

    for (int i = 0; i < 3; i++) begin
      invert = tbl[i].inv;
      exp_q.push_back(tbl[i].exp);
      steps(tbl[i].n);
      repeat (5) @(negedge clock);
      check($sformatf("dir_pos_%0d", i), position, exp_q.pop_front());
    end
    invert = 1'b0;

    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_position", position, 32'd0);
    check("async_rst_velocity", velocity, 32'd0);
    check("async_rst_update", 32'(update_controller), 32'd0);
    #1 reset_n = 1'b1;
    mpos = 32'sd0;
    repeat (20) @(negedge clock);
    check("reprime_no_count", position, 32'd0);
    steps(4);
    repeat (2) @(negedge clock);
    check("after_reset_fwd4", position, 32'd4);

    wait_strobe(t0);
    steps(25);
    exp_q.push_back(32'sd25);
    wait_strobe(t1);
    check("vel_fwd25", velocity, exp_q.pop_front());
    check("period_1", t1 - t0, P);
    @(negedge clock);
    check("pulse_width", 32'(update_controller), 32'd0);
    steps(-7);
    exp_q.push_back(-32'sd7);
    wait_strobe(t2);
    check("vel_rev7", velocity, exp_q.pop_front());
    check("period_2", t2 - t1, P);

    @(negedge clock);
    enc_a = ~enc_a;
    repeat (2) @(negedge clock);
    enc_a = ~enc_a;
    repeat (20) @(negedge clock);
    check("glitch_pos", position, mpos);
    check("glitch_err", 32'(error_count), 32'd0);
    idx = (idx + 2) % 4;
    {enc_a, enc_b} = gray(idx);
    repeat (20) @(negedge clock);
    check("illegal_pos", position, mpos);
    check("illegal_err", 32'(error_count), 32'd1);
    steps(1);
    repeat (2) @(negedge clock);
    check("post_illegal_fwd", position, mpos);

    @(negedge clock);
    zero_position = 1'b1;
    @(negedge clock);
    zero_position = 1'b0;
    mpos = 32'sd0;
    @(negedge clock);
    check("zero_pos", position, 32'd0);
    steps(-1);
    repeat (2) @(negedge clock);
    check("wrap_neg1", position, 32'hFFFF_FFFF);

    wait_strobe(t0);
    repeat (P - 6) @(posedge clock);
    @(negedge clock);
    idx = (idx + 3) % 4;
    {enc_a, enc_b} = gray(idx);
    @(posedge clock);
    repeat (4) @(posedge clock);
    @(negedge clock);
    zero_position = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("zero_tc_strobe", 32'(update_controller), 32'd1);
    check("zero_tc_velocity", velocity, 32'd0);
    check("zero_tc_position", position, 32'd0);
    zero_position = 1'b0;
    mpos = 32'sd0;
    repeat (20) @(negedge clock);
    check("zero_tc_hold", position, 32'd0);

    @(negedge clock);
    enable = 1'b0;
    @(posedge clock);
    s0 = strobe_total;
    steps(50);
    repeat (2000) @(posedge clock);
    s1 = strobe_total;
    check("disabled_strobes", s1 - s0, 32'd0);
    @(negedge clock);
    check("disabled_velocity", velocity, 32'd0);
    check("disabled_position", position, mpos);
    enable = 1'b1;
    n = 0; found = 1'b0;
    for (int k = 0; k < 2 * P && !found; k++) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (update_controller) found = 1'b1;
    end
    check("enable_first_strobe", n, P);
    check("enable_velocity", velocity, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
